// File: rtl/weight_fetch_pkg.sv
// Shared types and helpers for the weight_fetch block (FSM state encoding, widths).
// Optional build macro used by this slice: WEIGHT_FETCH_ROW_REVERSE_EN.
package weight_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FETCH     = 2'd1,
        START     = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam int FIFO_WIDTH_DEFAULT = 16;
    localparam int ROW_IDX_W          = $clog2(FIFO_WIDTH_DEFAULT);

    function automatic int row_data_w(input int fifo_width, input int data_width);
        return fifo_width * data_width;
    endfunction

endpackage

// File: rtl/weight_fetch_addr_gen.sv
// Base-address register and row counter for weight_fetch; produces the memory row address.
// With WEIGHT_FETCH_ROW_REVERSE_EN defined, rows are read bottom-up (base+N-1 first).
module weight_fetch_addr_gen
    import weight_fetch_pkg::*;
#(
    parameter int FIFO_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int ROW_W      = ROW_IDX_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic                  advance,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [ROW_W-1:0]      row,
    output logic                  last
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(FIFO_WIDTH - 1);

    logic [ADDR_WIDTH-1:0] base_reg;
    logic [ROW_W-1:0]      cnt_reg;
    logic [ADDR_WIDTH-1:0] offset;

    always_ff @(posedge clk) begin
        if (reset) begin
            base_reg <= '0;
            cnt_reg  <= '0;
        end else if (load) begin
            base_reg <= load_addr;
            cnt_reg  <= '0;
        end else if (advance) begin
            cnt_reg <= last ? '0 : cnt_reg + ROW_W'(1);
        end
    end

`ifdef WEIGHT_FETCH_ROW_REVERSE_EN
    assign offset = ADDR_WIDTH'(LAST_ROW) - ADDR_WIDTH'(cnt_reg);
`else
    assign offset = ADDR_WIDTH'(cnt_reg);
`endif

    // Sum is truncated to ADDR_WIDTH, so the address wraps modulo 2^ADDR_WIDTH.
    assign addr = base_reg + offset;
    assign row  = cnt_reg;
    assign last = (cnt_reg == LAST_ROW);

endmodule

// File: rtl/weight_fetch.sv
// Weight-load feeder: reads FIFO_WIDTH rows from weight memory into the weight FIFO,
// then starts the FIFO controller and waits for it. Build option: WEIGHT_FETCH_ROW_REVERSE_EN.
module weight_fetch
    import weight_fetch_pkg::*;
#(
    parameter int FIFO_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [ADDR_WIDTH-1:0]            cmd_addr,
    input  logic                             cmd_stagger,
    output logic                             mem_rd_en,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    input  logic [FIFO_WIDTH*DATA_WIDTH-1:0] mem_rd_data,
    output logic                             wr_valid,
    output logic [$clog2(FIFO_WIDTH)-1:0]    wr_row,
    output logic [FIFO_WIDTH*DATA_WIDTH-1:0] wr_data,
    output logic                             ctrl_active,
    output logic                             ctrl_stagger,
    input  logic                             ctrl_done,
    output logic                             busy
);

    localparam int ROW_W  = $clog2(FIFO_WIDTH);
    localparam int ROW_DW = row_data_w(FIFO_WIDTH, DATA_WIDTH);

    state_t state_reg, state_next;

    logic                  cmd_ready_reg;
    logic                  stagger_reg;
    logic                  guard_reg;
    logic                  pend_valid_reg;
    logic [ROW_W-1:0]      pend_row_reg;

    logic                  accept;
    logic                  fetch_c;
    logic                  start_c;
    logic                  busy_c;
    logic                  hold_stagger_c;
    logic [ADDR_WIDTH-1:0] gen_addr;
    logic [ROW_W-1:0]      gen_row;
    logic                  gen_last;
    logic [ROW_DW-1:0]     wr_data_c;

    // cmd_ready_reg is only ever set when the FSM is heading into IDLE.
    assign accept = cmd_valid & cmd_ready_reg;

    weight_fetch_addr_gen #(
        .FIFO_WIDTH (FIFO_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .ROW_W      (ROW_W)
    ) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .load      (accept),
        .load_addr (cmd_addr),
        .advance   (fetch_c),
        .addr      (gen_addr),
        .row       (gen_row),
        .last      (gen_last)
    );

    always_comb begin
        state_next     = state_reg;
        fetch_c        = 1'b0;
        start_c        = 1'b0;
        busy_c         = 1'b1;
        hold_stagger_c = 1'b0;
        case (state_reg)
            IDLE: begin
                busy_c = 1'b0;
                if (accept) state_next = FETCH;
            end
            FETCH: begin
                fetch_c = 1'b1;
                if (gen_last) state_next = START;
            end
            START: begin
                start_c        = 1'b1;
                hold_stagger_c = 1'b1;
                state_next     = WAIT_DONE;
            end
            WAIT_DONE: begin
                hold_stagger_c = 1'b1;
                // The controller only sees the start pulse a cycle later, so its
                // first-cycle done level is stale.
                if (!guard_reg && ctrl_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            cmd_ready_reg  <= 1'b0;
            stagger_reg    <= 1'b0;
            guard_reg      <= 1'b0;
            pend_valid_reg <= 1'b0;
            pend_row_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            cmd_ready_reg  <= (state_next == IDLE);
            guard_reg      <= (state_reg == START);
            pend_valid_reg <= fetch_c;
            pend_row_reg   <= fetch_c ? gen_row : '0;
            if (accept) stagger_reg <= cmd_stagger;
        end
    end

    // The memory read port is itself registered; the lane gating only masks
    // the data outside a pending read.
    for (genvar gi = 0; gi < FIFO_WIDTH; gi++) begin : g_lane
        assign wr_data_c[gi*DATA_WIDTH +: DATA_WIDTH] =
            pend_valid_reg ? mem_rd_data[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
    end

    assign cmd_ready    = cmd_ready_reg;
    assign mem_rd_en    = fetch_c;
    assign mem_addr     = fetch_c ? gen_addr : '0;
    assign wr_valid     = pend_valid_reg;
    assign wr_row       = pend_row_reg;
    assign wr_data      = wr_data_c;
    assign ctrl_active  = start_c;
    assign ctrl_stagger = stagger_reg & hold_stagger_c;
    assign busy         = busy_c;

endmodule

// File: tb/tb_weight_fetch.sv
// Scoreboard bench for weight_fetch: the driver queues expected reads, writes, start pulses
// and idle returns; a negedge monitor pops and compares. Honors WEIGHT_FETCH_ROW_REVERSE_EN.
module tb_weight_fetch;

    localparam int N   = 16;
    localparam int DW  = 8;
    localparam int AW  = 16;
    localparam int RW  = 4;
    localparam int RDW = N * DW;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [AW-1:0]  cmd_addr = '0;
    logic           cmd_stagger = 1'b0;
    logic           mem_rd_en;
    logic [AW-1:0]  mem_addr;
    logic [RDW-1:0] mem_rd_data = '0;
    logic           wr_valid;
    logic [RW-1:0]  wr_row;
    logic [RDW-1:0] wr_data;
    logic           ctrl_active;
    logic           ctrl_stagger;
    logic           ctrl_done = 1'b1;
    logic           busy;

    weight_fetch #(.FIFO_WIDTH(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_addr     (cmd_addr),
        .cmd_stagger  (cmd_stagger),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_rd_data  (mem_rd_data),
        .wr_valid     (wr_valid),
        .wr_row       (wr_row),
        .wr_data      (wr_data),
        .ctrl_active  (ctrl_active),
        .ctrl_stagger (ctrl_stagger),
        .ctrl_done    (ctrl_done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [RDW-1:0] pattern(input logic [AW-1:0] a);
        return {8{a ^ 16'h5A5A}};
    endfunction

    // Memory model: registered read, data valid the cycle after mem_rd_en.
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= pattern(mem_addr);

    function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] base, input int k);
`ifdef WEIGHT_FETCH_ROW_REVERSE_EN
        return base + AW'(N - 1 - k);
`else
        return base + AW'(k);
`endif
    endfunction

    typedef struct { int cyc; logic [AW-1:0] addr; } rd_t;
    typedef struct { int cyc; logic [RW-1:0] row; logic [RDW-1:0] data; } wr_t;
    typedef struct { int cyc; logic stg; } ctl_t;
    typedef struct { int cyc; logic rdy; } idle_t;

    rd_t   rd_q[$];
    wr_t   wr_q[$];
    ctl_t  ctl_q[$];
    idle_t idle_q[$];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [RDW-1:0] act, input logic [RDW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        failures++;
        $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
    endtask

    // Monitor
    rd_t   m_rd;
    wr_t   m_wr;
    ctl_t  m_ctl;
    idle_t m_idle;
    logic  prev_busy = 1'b0;
    logic  held = 1'b0;
    logic  held_stg = 1'b0;

    always @(negedge clk) begin
        if (mem_rd_en === 1'b1) begin
            if (rd_q.size() == 0) flag("read_unexpected");
            else begin
                m_rd = rd_q.pop_front();
                chk("read_cycle", RDW'(cyc), RDW'(m_rd.cyc));
                chk("read_addr", RDW'(mem_addr), RDW'(m_rd.addr));
                $display("read  cyc=%0d addr=%04h", cyc, mem_addr);
            end
        end
        if (wr_valid === 1'b1) begin
            if (wr_q.size() == 0) flag("write_unexpected");
            else begin
                m_wr = wr_q.pop_front();
                chk("write_cycle", RDW'(cyc), RDW'(m_wr.cyc));
                chk("write_row", RDW'(wr_row), RDW'(m_wr.row));
                chk("write_data", wr_data, m_wr.data);
                $display("write cyc=%0d row=%0d data=%0h", cyc, wr_row, wr_data);
            end
        end
        if (ctrl_active === 1'b1) begin
            if (ctl_q.size() == 0) flag("ctrl_active_unexpected");
            else begin
                m_ctl = ctl_q.pop_front();
                chk("ctrl_active_cycle", RDW'(cyc), RDW'(m_ctl.cyc));
                chk("ctrl_stagger_at_start", RDW'(ctrl_stagger), RDW'(m_ctl.stg));
                held     <= 1'b1;
                held_stg <= m_ctl.stg;
                $display("start cyc=%0d stagger=%0b", cyc, ctrl_stagger);
            end
        end else if (held && busy === 1'b1) begin
            chk("ctrl_stagger_held", RDW'(ctrl_stagger), RDW'(held_stg));
        end
        if (prev_busy === 1'b1 && busy === 1'b0) begin
            held <= 1'b0;
            if (idle_q.size() == 0) flag("idle_unexpected");
            else begin
                m_idle = idle_q.pop_front();
                chk("idle_cycle", RDW'(cyc), RDW'(m_idle.cyc));
                chk("idle_cmd_ready", RDW'(cmd_ready), RDW'(m_idle.rdy));
                $display("idle  cyc=%0d cmd_ready=%0b", cyc, cmd_ready);
            end
        end
        prev_busy <= busy;
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cmd_ready"}, RDW'(cmd_ready), '0);
        chk({tag, "_mem_rd_en"}, RDW'(mem_rd_en), '0);
        chk({tag, "_mem_addr"}, RDW'(mem_addr), '0);
        chk({tag, "_wr_valid"}, RDW'(wr_valid), '0);
        chk({tag, "_wr_row"}, RDW'(wr_row), '0);
        chk({tag, "_wr_data"}, wr_data, '0);
        chk({tag, "_ctrl_active"}, RDW'(ctrl_active), '0);
        chk({tag, "_ctrl_stagger"}, RDW'(ctrl_stagger), '0);
        chk({tag, "_busy"}, RDW'(busy), '0);
    endtask

    // Presents a command, waits (bounded) for the handshake, and queues the expected response.
    task automatic issue(input logic [AW-1:0] a, input logic stg, input int n_rd, input int n_wr,
                         input bit with_ctl, input int idle_off, output int c0);
        int n;
        logic [AW-1:0] ea;
        @(negedge clk);
        cmd_valid   = 1'b1;
        cmd_addr    = a;
        cmd_stagger = stg;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        c0 = cyc;
        if (cmd_ready !== 1'b1) begin
            flag("handshake_timeout");
            cmd_valid = 1'b0;
            return;
        end
        for (int k = 0; k < n_rd; k++) begin
            ea = exp_addr(a, k);
            rd_q.push_back('{cyc: c0 + 1 + k, addr: ea});
        end
        for (int k = 0; k < n_wr; k++) begin
            ea = exp_addr(a, k);
            wr_q.push_back('{cyc: c0 + 2 + k, row: RW'(k), data: pattern(ea)});
        end
        if (with_ctl) ctl_q.push_back('{cyc: c0 + N + 1, stg: stg});
        if (idle_off >= 0) idle_q.push_back('{cyc: c0 + idle_off, rdy: (idle_off >= N + 4)});
        $display("cmd   cyc=%0d addr=%04h stagger=%0b", c0, a, stg);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    initial begin
        int c0;
        // Reset state
        @(negedge clk);
        chk_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_cmd_ready", RDW'(cmd_ready), RDW'(1));
        chk("post_reset_busy", RDW'(busy), '0);

        // Basic load with ctrl_done held high: guard delays idle to N+4
        issue(16'h0100, 1'b0, N, N, 1'b1, N + 4, c0);
        // Stagger forwarding, then cleared on the next command
        issue(16'h0200, 1'b1, N, N, 1'b1, N + 4, c0);
        issue(16'h0300, 1'b0, N, N, 1'b1, N + 4, c0);
        // Address wrap
        issue(16'hFFF8, 1'b1, N, N, 1'b1, N + 4, c0);

        // ctrl_done low for 40 cycles of WAIT_DONE
        wait_cyc(cyc + 1);
        while (busy === 1'b1) @(negedge clk);
        ctrl_done = 1'b0;
        issue(16'h0400, 1'b1, N, N, 1'b1, -1, c0);
        wait_cyc(c0 + N + 2 + 40);
        chk("wait_done_busy", RDW'(busy), RDW'(1));
        chk("wait_done_cmd_ready", RDW'(cmd_ready), '0);
        ctrl_done = 1'b1;
        idle_q.push_back('{cyc: cyc + 1, rdy: 1'b1});

        // Reset during FETCH: reads k=0..4, writes rows 0..3, row 4 discarded
        issue(16'h0500, 1'b1, 5, 4, 1'b0, 6, c0);
        wait_cyc(c0 + 5);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_all_zero("mid_reset");
        @(negedge clk);
        chk("after_mid_reset_cmd_ready", RDW'(cmd_ready), RDW'(1));
        chk("after_mid_reset_wr_valid", RDW'(wr_valid), '0);

        // Clean load after the reset
        issue(16'h0600, 1'b1, N, N, 1'b1, N + 4, c0);
        wait_cyc(c0 + N + 8);

        chk("rd_q_drained", RDW'(rd_q.size()), '0);
        chk("wr_q_drained", RDW'(wr_q.size()), '0);
        chk("ctl_q_drained", RDW'(ctl_q.size()), '0);
        chk("idle_q_drained", RDW'(idle_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
